// File: rtl/twofish_mode_engine.sv
// Block-cipher mode wrapper around an external Twofish core: buffers input
// blocks in a small FIFO, feeds the core one block at a time and applies
// ECB / CBC / CTR chaining to the results.
`timescale 1ns/1ps
module twofish_mode_engine #(
    parameter int FIFO_DEPTH = 4,
    parameter int KEY_W      = 128
) (
    input  logic             Clk,
    input  logic             Reset,
    input  logic             Start,
    input  logic             EnDe,
    input  logic [1:0]       Mode,
    input  logic [KEY_W-1:0] key,
    input  logic [127:0]     iv,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [127:0]     in_data,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [127:0]     out_data,
    output logic             busy,
    output logic             core_start,
    output logic             core_EnDe,
    output logic [127:0]     core_block,
    output logic [KEY_W-1:0] core_key,
    input  logic [127:0]     core_o,
    input  logic             core_busy
);
    localparam int AW = $clog2(FIFO_DEPTH);

    typedef enum logic [2:0] {IDLE, LAUNCH, WAIT_BUSY, WAIT_DONE, EMIT} state_t;
    state_t state_q, state_d;

    logic                             session_active;
    logic                             ende_q;
    logic [1:0]                       mode_q;
    logic [KEY_W-1:0]                 key_q;
    logic [127:0]                     chain_q, ctr_q;
    logic [FIFO_DEPTH-1:0][127:0]     mem;
    logic [AW:0]                      wptr, rptr;
    logic [127:0]                     in_q;          // input block of the one in flight
    logic [127:0]                     core_block_q;
    logic                             core_ende_q;
    logic                             out_valid_q;
    logic [127:0]                     out_data_q;

    logic         empty, full, push, pop, busy_int, start_acc;
    logic         is_cbc, is_ctr;
    logic [127:0] head, launch_blk, emit_data;
    logic         launch_ende;

    assign empty     = (wptr == rptr);
    assign full      = (wptr[AW] != rptr[AW]) && (wptr[AW-1:0] == rptr[AW-1:0]);
    assign head      = mem[rptr[AW-1:0]];
    assign push      = in_valid && session_active && !full;
    assign pop       = (state_q == IDLE) && !empty && !out_valid_q;
    assign busy_int  = (state_q != IDLE) || !empty || out_valid_q;
    assign start_acc = Start && !busy_int;

    // Mode 11 falls through to ECB behaviour because neither flag is set.
    assign is_cbc      = (mode_q == 2'b01);
    assign is_ctr      = (mode_q == 2'b10);
    assign launch_blk  = is_ctr ? ctr_q : ((is_cbc && !ende_q) ? (head ^ chain_q) : head);
    assign launch_ende = is_ctr ? 1'b0 : ende_q;
    assign emit_data   = is_ctr ? (in_q ^ core_o) : ((is_cbc && ende_q) ? (core_o ^ chain_q) : core_o);

    // Outputs are forced quiet while Reset is asserted, not just after it.
    assign in_ready   = session_active && !full && !Reset;
    assign busy       = busy_int && !Reset;
    assign out_valid  = out_valid_q && !Reset;
    assign out_data   = Reset ? 128'd0 : out_data_q;
    assign core_start = (state_q == LAUNCH) && !Reset;
    assign core_block = Reset ? 128'd0 : core_block_q;
    assign core_EnDe  = core_ende_q;
    assign core_key   = key_q;

    // FSM state register
    always_ff @(posedge Clk) begin
        if (Reset) state_q <= IDLE;
        else       state_q <= state_d;
    end

    // FSM next-state: one block in flight, core handshake via busy rise/fall
    always_comb begin
        state_d = state_q;
        case (state_q)
            IDLE:      if (!empty && !out_valid_q) state_d = LAUNCH;
            LAUNCH:    state_d = WAIT_BUSY;
            WAIT_BUSY: if (core_busy) state_d = WAIT_DONE;
            WAIT_DONE: if (!core_busy) state_d = EMIT;
            EMIT:      state_d = IDLE;
            default:   state_d = IDLE;
        endcase
    end

    // FIFO storage, no reset needed since pointers define validity
    always_ff @(posedge Clk) begin
        if (push && !Reset && !start_acc) mem[wptr[AW-1:0]] <= in_data;
    end

    // Session, FIFO pointers, core request and output registers
    always_ff @(posedge Clk) begin
        if (Reset) begin
            session_active <= 1'b0;
            ende_q         <= 1'b0;
            mode_q         <= 2'b00;
            key_q          <= '0;
            chain_q        <= '0;
            ctr_q          <= '0;
            wptr           <= '0;
            rptr           <= '0;
            in_q           <= '0;
            core_block_q   <= '0;
            core_ende_q    <= 1'b0;
            out_valid_q    <= 1'b0;
            out_data_q     <= '0;
        end else begin
            if (start_acc) begin
                session_active <= 1'b1;
                ende_q         <= EnDe;
                mode_q         <= Mode;
                key_q          <= key;
                chain_q        <= iv;
                ctr_q          <= iv;
                wptr           <= '0;
                rptr           <= '0;
            end else begin
                if (push) wptr <= wptr + (AW+1)'(1);
                if (pop)  rptr <= rptr + (AW+1)'(1);
            end
            // Request is captured on the pop so it is valid alongside core_start.
            if (pop) begin
                core_block_q <= launch_blk;
                core_ende_q  <= launch_ende;
                in_q         <= head;
            end
            if (state_q == EMIT) begin
                out_data_q  <= emit_data;
                out_valid_q <= 1'b1;
                if (is_cbc) chain_q <= ende_q ? in_q : core_o;
                if (is_ctr) ctr_q   <= ctr_q + 128'd1;
            end else if (out_valid_q && out_ready) begin
                out_valid_q <= 1'b0;
            end
        end
    end
endmodule

// File: tb/tb_twofish_mode_engine.sv
// Directed bench for twofish_mode_engine with an XOR stub core.
`timescale 1ns/1ps
module tb_twofish_mode_engine;
    logic         Clk = 1'b0;
    logic         Reset = 1'b1, Start = 1'b0, EnDe = 1'b0;
    logic [1:0]   Mode = 2'b00;
    logic [127:0] key = '0, iv = '0;
    logic         in_valid = 1'b0, in_ready;
    logic [127:0] in_data = '0;
    logic         out_valid, out_ready = 1'b0;
    logic [127:0] out_data;
    logic         busy, core_start, core_EnDe, core_busy;
    logic [127:0] core_block, core_key, core_o;
    logic         force_busy = 1'b0;
    logic [3:0]   cnt = '0;
    int           checks = 0, failures = 0;
    int           nstart = 0, nende = 0;
    int           s0, e0, n;
    logic [127:0] ones;

    always #5 Clk = ~Clk;

    twofish_mode_engine #(.FIFO_DEPTH(4), .KEY_W(128)) dut (
        .Clk(Clk), .Reset(Reset), .Start(Start), .EnDe(EnDe), .Mode(Mode),
        .key(key), .iv(iv), .in_valid(in_valid), .in_ready(in_ready),
        .in_data(in_data), .out_valid(out_valid), .out_ready(out_ready),
        .out_data(out_data), .busy(busy), .core_start(core_start),
        .core_EnDe(core_EnDe), .core_block(core_block), .core_key(core_key),
        .core_o(core_o), .core_busy(core_busy));

    // stub core: XOR cipher, busy for 10 cycles after each start
    assign core_o    = core_block ^ core_key;
    assign core_busy = (cnt != 4'd0) || force_busy;
    always @(posedge Clk) begin
        if (core_start) cnt <= 4'd10;
        else if (cnt != 4'd0) cnt <= cnt - 4'd1;
    end

    // count core launches and launches that requested decrypt
    always @(posedge Clk) begin
        if (core_start === 1'b1) nstart <= nstart + 1;
        if (core_start === 1'b1 && core_EnDe === 1'b1) nende <= nende + 1;
    end

    task automatic chk(input string tag, input logic [127:0] obs, input logic [127:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic cyc(input int c);
        repeat (c) begin @(posedge Clk); #1; end
    endtask

    task automatic do_start(input logic e, input logic [1:0] m, input logic [127:0] k, input logic [127:0] v);
        int w = 0;
        while (busy !== 1'b0 && w < 300) begin cyc(1); w++; end
        chk("start_idle", {127'd0, busy}, 128'd0);
        EnDe = e; Mode = m; key = k; iv = v; Start = 1'b1;
        cyc(1);
        Start = 1'b0;
    endtask

    task automatic push(input logic [127:0] d);
        int w = 0;
        in_valid = 1'b1; in_data = d;
        while (in_ready !== 1'b1 && w < 300) begin cyc(1); w++; end
        chk("push_ready", {127'd0, in_ready}, 128'd1);
        cyc(1);
        in_valid = 1'b0;
    endtask

    task automatic get_out(input string tag, input logic [127:0] exp);
        int w = 0;
        out_ready = 1'b1;
        while (out_valid !== 1'b1 && w < 300) begin cyc(1); w++; end
        chk({tag, "_valid"}, {127'd0, out_valid}, 128'd1);
        chk(tag, out_data, exp);
        cyc(1);
        out_ready = 1'b0;
    endtask

    initial begin
        ones = '1;
        // reset held two cycles
        cyc(2);
        chk("rst_out_valid", {127'd0, out_valid}, 128'd0);
        chk("rst_in_ready", {127'd0, in_ready}, 128'd0);
        chk("rst_busy", {127'd0, busy}, 128'd0);
        chk("rst_core_start", {127'd0, core_start}, 128'd0);
        chk("rst_out_data", out_data, 128'd0);
        chk("rst_core_block", core_block, 128'd0);
        Reset = 1'b0;
        cyc(1);
        chk("post_rst_in_ready", {127'd0, in_ready}, 128'd0);

        // ECB encrypt, single launch
        s0 = nstart;
        do_start(1'b0, 2'b00, 128'hF0, 128'd0);
        chk("ecb_key", core_key, 128'hF0);
        push(128'h0F);
        get_out("ecb_out", 128'hFF);
        cyc(3);
        chk("ecb_one_start", 128'(nstart - s0), 128'd1);
        chk("ecb_idle", {127'd0, busy}, 128'd0);

        // CBC encrypt then decrypt
        do_start(1'b0, 2'b01, 128'd0, 128'h1);
        push(128'h2); push(128'h4);
        get_out("cbc_enc0", 128'h3);
        get_out("cbc_enc1", 128'h7);
        do_start(1'b1, 2'b01, 128'd0, 128'h1);
        push(128'h3); push(128'h7);
        get_out("cbc_dec0", 128'h2);
        get_out("cbc_dec1", 128'h4);

        // CTR with decrypt requested: counter wraps, core always encrypts
        e0 = nende;
        do_start(1'b1, 2'b10, 128'd0, ones);
        push(128'd0); push(128'd0);
        get_out("ctr0", ones);
        get_out("ctr1", 128'd0);
        cyc(2);
        chk("ctr_core_ende", 128'(nende - e0), 128'd0);

        // mode 11 acts as ECB, decrypt direction reaches the core
        do_start(1'b1, 2'b11, 128'h5, 128'h99);
        push(128'h3);
        get_out("m11_out", 128'h6);
        chk("m11_core_ende", {127'd0, core_EnDe}, 128'd1);

        // backpressure: core stuck busy, FIFO fills, Start ignored, output held
        do_start(1'b0, 2'b00, 128'd0, 128'd0);
        force_busy = 1'b1;
        for (int i = 1; i <= 5; i++) push(128'(i));
        chk("full_in_ready", {127'd0, in_ready}, 128'd0);
        chk("full_busy", {127'd0, busy}, 128'd1);
        key = 128'hFF; Start = 1'b1;
        cyc(1);
        Start = 1'b0;
        chk("ignored_start_key", core_key, 128'd0);
        force_busy = 1'b0;
        n = 0;
        while (out_valid !== 1'b1 && n < 300) begin cyc(1); n++; end
        cyc(5);
        chk("hold_valid", {127'd0, out_valid}, 128'd1);
        chk("hold_data", out_data, 128'd1);
        for (int i = 1; i <= 5; i++) get_out("bp_out", 128'(i));
        chk("drained_in_ready", {127'd0, in_ready}, 128'd1);

        // reset while waiting on the core, then a fresh session
        do_start(1'b0, 2'b00, 128'h10, 128'd0);
        force_busy = 1'b1;
        push(128'h1);
        cyc(4);
        Reset = 1'b1;
        cyc(1);
        Reset = 1'b0;
        chk("midrst_busy", {127'd0, busy}, 128'd0);
        chk("midrst_out_valid", {127'd0, out_valid}, 128'd0);
        chk("midrst_in_ready", {127'd0, in_ready}, 128'd0);
        force_busy = 1'b0;
        do_start(1'b0, 2'b00, 128'h20, 128'd0);
        push(128'h3);
        get_out("after_rst_out", 128'h23);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule

// File: doc/twofish_mode_engine.md
TWOFISH_MODE_ENGINE -- requirements
Module: twofish_mode_engine

Interface
REQ-001 Parameter FIFO_DEPTH, default 4: input FIFO depth in 128-bit blocks, power of two, >= 2.
REQ-002 Parameter KEY_W, default 128: key width passed through to the core.
REQ-003 Clk  in  1  single clock; all logic on the rising edge.
REQ-004 Reset  in  1  synchronous, active-high reset.
REQ-005 Start  in  1  one-cycle pulse; latches EnDe, Mode, key, iv and opens a session.
REQ-006 EnDe  in  1  0 = encrypt, 1 = decrypt.
REQ-007 Mode  in  2  00 ECB, 01 CBC, 10 CTR; 11 behaves as ECB.
REQ-008 key  in  KEY_W  session key; iv  in  128  CBC chain seed or CTR initial counter.
REQ-009 in_valid / in_ready / in_data[127:0]  in / out / in: input block stream, transfer when valid && ready.
REQ-010 out_valid / out_ready / out_data[127:0]  out / in / out: output block stream, transfer when valid && ready.
REQ-011 busy  out  1  high while the session has work: FSM not IDLE, FIFO non-empty, or out_valid.
REQ-012 core_start  out  1; core_EnDe  out  1; core_block  out  128; core_key  out  KEY_W: block-cipher core request.
REQ-013 core_o  in  128; core_busy  in  1: core result and status.

Function
REQ-014 Start SHALL be accepted only when busy = 0; Start while busy = 1 is ignored with no state change.
REQ-015 Accepted Start SHALL set session_active, clear the FIFO, load chain register from iv and counter from iv.
REQ-016 in_ready SHALL equal session_active && FIFO not full; a push when full is impossible.
REQ-017 FSM states: IDLE, LAUNCH, WAIT_BUSY, WAIT_DONE, EMIT.
REQ-018 IDLE -> LAUNCH when FIFO non-empty and out_valid = 0.
REQ-019 LAUNCH: core_start = 1 for exactly one cycle, head block popped, core_block/core_EnDe registered and held stable until WAIT_DONE exits; -> WAIT_BUSY.
REQ-020 WAIT_BUSY -> WAIT_DONE when core_busy = 1; WAIT_DONE -> EMIT when core_busy = 0.
REQ-021 EMIT: out_data computed from core_o, out_valid set, chain/counter updated, -> IDLE; all in the same cycle.
REQ-022 out_valid SHALL stay high and out_data stable until out_ready = 1.
REQ-023 ECB: core_block = in; core_EnDe = EnDe; out = core_o.
REQ-024 CBC encrypt: core_block = in ^ chain; out = core_o; chain <= core_o.
REQ-025 CBC decrypt: core_block = in; out = core_o ^ chain; chain <= in (the ciphertext block).
REQ-026 CTR: core_block = counter; core_EnDe = 0 regardless of EnDe; out = in ^ core_o; counter <= counter + 1 mod 2^128 (all-ones wraps to zero).
REQ-027 core_key SHALL equal the latched session key throughout a session.
REQ-028 Blocks SHALL emerge in input order; one block in flight at a time.
REQ-029 Simultaneous FIFO push and pop SHALL keep occupancy unchanged.

Reset
REQ-030 Reset SHALL force FSM to IDLE, empty the FIFO, and clear session_active, chain, counter, latched key and mode.
REQ-031 During and after Reset: out_valid, in_ready, busy, core_start = 0; out_data, core_block = 0.
REQ-032 Reset mid-operation SHALL abandon the in-flight block; core_busy is ignored until the next LAUNCH.
REQ-033 Reset SHALL take priority over Start and all handshakes in the same cycle.

Verification (stub core: core_o = core_block ^ core_key, core_busy high 10 cycles after core_start)
REQ-034 Reset held 2 cycles -> out_valid = in_ready = busy = core_start = 0; out_data = 0.
REQ-035 ECB, key = 128'hF0, in 128'h0F -> out_data = 128'hFF; exactly one core_start pulse.
REQ-036 CBC encrypt, key = 0, iv = 128'h1, in 128'h2 then 128'h4 -> out 128'h3 then 128'h7; CBC decrypt of 3, 7 with same iv -> 2, 4.
REQ-037 CTR, EnDe = 1, key = 0, iv = all-ones, in 0 twice -> out all-ones then 0; core_EnDe = 0 throughout.
REQ-038 core_busy held high, push FIFO_DEPTH+1 blocks -> in_ready = 0 after FIFO fills; out_ready = 0 holds out_data stable; Start while busy ignored.
REQ-039 Reset asserted in WAIT_DONE -> next cycle busy = 0, out_valid = 0; a new session runs and produces correct output.
